// File: rtl/ad_ip_jesd204_tpl_dac_framer_fifo.sv
// Elastic FIFO and JESD204 transport-layer framer for the TPL DAC datapath.
// Buffers channel-major DMA beats and emits one lane-major link beat per clock while the link is up.
module ad_ip_jesd204_tpl_dac_framer_fifo #(
  parameter int unsigned NUM_LANES       = 4,
  parameter int unsigned NUM_CHANNELS    = 2,
  parameter int unsigned BITS_PER_SAMPLE = 16,
  parameter int unsigned OCTETS_PER_BEAT = 4,
  parameter int unsigned FIFO_DEPTH      = 8,
  parameter int unsigned START_LEVEL     = 4,
  parameter int unsigned UNDERFLOW_MODE  = 0
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_CHANNELS-1:0]                enable,
  input  logic                                   s_valid,
  output logic                                   s_ready,
  input  logic [NUM_LANES*OCTETS_PER_BEAT*8-1:0] s_data,
  output logic                                   link_valid,
  input  logic                                   link_ready,
  output logic [NUM_LANES*OCTETS_PER_BEAT*8-1:0] link_data,
  output logic                                   dunf,
  output logic [15:0]                            dunf_count,
  output logic [$clog2(FIFO_DEPTH):0]            fifo_level
);
  localparam int unsigned LW    = NUM_LANES * OCTETS_PER_BEAT * 8;
  localparam int unsigned NP    = BITS_PER_SAMPLE;
  localparam int unsigned F     = NUM_CHANNELS * NP / (8 * NUM_LANES);
  localparam int unsigned FPB   = OCTETS_PER_BEAT / F;
  localparam int unsigned OPS   = NP / 8;
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = AW + 1;

  typedef enum logic [1:0] {StIdle, StFill, StRun} state_e;

  state_e           r_state;
  logic [LW-1:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic [LW-1:0]    r_last;
  logic             r_link_valid;
  logic [LW-1:0]    r_link_data;
  logic             r_dunf;
  logic [15:0]      r_dunf_count;

  logic             w_push;
  logic             w_pop;
  logic             w_unf;
  logic [LVL_W-1:0] w_level_nxt;
  logic [LW-1:0]    w_rd_beat;
  logic [LW-1:0]    w_src;
  logic [LW-1:0]    w_masked;
  logic [LW-1:0]    w_framed;

  assign s_ready     = (r_state != StIdle) && (r_level < LVL_W'(FIFO_DEPTH));
  assign w_push      = s_valid && s_ready;
  assign w_pop       = (r_state == StRun) && (r_level != '0);
  assign w_unf       = (r_state == StRun) && (r_level == '0);
  assign w_level_nxt = r_level + LVL_W'(w_push) - LVL_W'(w_pop);
  assign w_rd_beat   = r_mem[r_rd_ptr];
  // Mode 1 repeats the raw popped beat so that the current enable mask is applied again.
  assign w_src       = w_pop ? w_rd_beat : ((UNDERFLOW_MODE == 1) ? r_last : '0);

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_mask
    assign w_masked[c*FPB*NP +: FPB*NP] = enable[c] ? w_src[c*FPB*NP +: FPB*NP] : '0;
  end

  // Frame octet J (0 = MSB of {ch0..chM-1}) goes to lane J/F, lane octet k*F + J%F.
  for (genvar k = 0; k < FPB; k++) begin : g_frame
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      for (genvar i = 0; i < F; i++) begin : g_oct
        localparam int unsigned J = l * F + i;
        localparam int unsigned C = J / OPS;
        localparam int unsigned O = J % OPS;
        assign w_framed[l*OCTETS_PER_BEAT*8 + 8*(k*F+i) +: 8] =
          w_masked[(C*FPB+k)*NP + NP - 8 - 8*O +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= s_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= StIdle;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_last       <= '0;
      r_link_valid <= 1'b0;
      r_link_data  <= '0;
      r_dunf       <= 1'b0;
      r_dunf_count <= '0;
    end else if (!link_ready) begin
      // Link left DATA phase: flush everything, including the beat being popped.
      r_state      <= StIdle;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_last       <= '0;
      r_link_valid <= 1'b0;
      r_link_data  <= '0;
      r_dunf       <= 1'b0;
    end else begin
      r_dunf <= 1'b0;
      case (r_state)
        StIdle: begin
          r_state      <= StFill;
          r_link_valid <= 1'b1;
          r_link_data  <= '0;
        end
        StFill: begin
          if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
          end
          r_level      <= w_level_nxt;
          r_link_valid <= 1'b1;
          r_link_data  <= '0;
          if (w_level_nxt >= LVL_W'(START_LEVEL)) begin
            r_state <= StRun;
          end
        end
        StRun: begin
          if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
          end
          if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
            r_last   <= w_rd_beat;
          end
          r_level      <= w_level_nxt;
          r_link_valid <= 1'b1;
          r_link_data  <= w_framed;
          if (w_unf) begin
            r_dunf <= 1'b1;
            if (r_dunf_count != 16'hFFFF) begin
              r_dunf_count <= r_dunf_count + 16'd1;
            end
          end
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign link_valid = r_link_valid;
  assign link_data  = r_link_data;
  assign dunf       = r_dunf;
  assign dunf_count = r_dunf_count;
  assign fifo_level = r_level;

endmodule
